// File: rtl/kara_pkg.sv
// kara_pkg: shared constants, FSM state type and a reference carry-less
// multiply for the Karatsuba partial-product sequencer.
//   HALF_W  operand half width (16)
//   PROD_W  carry-less product width of two halves (31, bits 0..30)
//   CNT_W   width of the beat down-counter (holds 16/STEP, up to 16)
package kara_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned PROD_W = 31;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reference GF(2) product of two 16-bit halves.
  function automatic logic [PROD_W-1:0] clmul16(input logic [HALF_W-1:0] a,
                                                input logic [HALF_W-1:0] b);
    logic [PROD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(HALF_W); i++) begin
      if (b[i]) r = r ^ (PROD_W'(a) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/clmul_step.sv
// clmul_step: one STEP-bit slice of a shift-and-XOR carry-less multiply.
//   acc_in    current accumulator
//   mcand     multiplicand, already aligned for this beat
//   mult_bits low STEP bits of the remaining multiplier
//   acc_out   acc_in XOR (mcand << j) for every set mult_bits[j]
// Purely combinational.
module clmul_step
  import kara_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic [PROD_W-1:0] acc_in,
  input  logic [PROD_W-1:0] mcand,
  input  logic [STEP-1:0]   mult_bits,
  output logic [PROD_W-1:0] acc_out
);

  always_comb begin
    acc_out = acc_in;
    for (int j = 0; j < int'(STEP); j++) begin
      if (mult_bits[j]) acc_out = acc_out ^ (mcand << j);
    end
  end

endmodule

// File: rtl/kara_pp_seq.sv
// kara_pp_seq: sequential producer of the three Karatsuba partial products
// of a 32x32 carry-less multiply, STEP multiplier bits per cycle.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (a, b sampled on accept edge)
//   a, b                 operands; [15:0] low half, [31:16] high half
//   out_valid/out_ready  result handshake
//   z0                   a_lo * b_lo
//   z1                   (a_lo ^ a_hi) * (b_lo ^ b_hi)
//   z2                   a_hi * b_hi
//
// state | meaning
// IDLE  | waiting for operands (in_ready high once out of reset)
// BUSY  | one STEP-bit slice per cycle, count runs down to zero
// DONE  | results held on z0/z1/z2 with out_valid until out_ready
module kara_pp_seq
  import kara_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] z0,
  output logic [PROD_W-1:0] z1,
  output logic [PROD_W-1:0] z2
);

  localparam logic [CNT_W-1:0] N_BEATS = CNT_W'(HALF_W / STEP);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Index 0 -> z0 (lo*lo), 1 -> z1 (mid), 2 -> z2 (hi*hi).
  logic [PROD_W-1:0] mcand_q [3];
  logic [PROD_W-1:0] mcand_d [3];
  logic [HALF_W-1:0] mult_q  [3];
  logic [HALF_W-1:0] mult_d  [3];
  logic [PROD_W-1:0] acc_q   [3];
  logic [PROD_W-1:0] acc_d   [3];
  logic [PROD_W-1:0] acc_nxt [3];
  logic [PROD_W-1:0] z_q     [3];
  logic [PROD_W-1:0] z_d     [3];

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic              accept;

  assign a_lo = a[15:0];
  assign a_hi = a[31:16];
  assign b_lo = b[15:0];
  assign b_hi = b[31:16];

  // in_ready_q is low during reset even though the state is IDLE, so the
  // first edge after release cannot accept.
  assign accept = (state_q == IDLE) && in_ready_q && in_valid;

  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    clmul_step #(
      .STEP (STEP)
    ) u_step (
      .acc_in    (acc_q[gi]),
      .mcand     (mcand_q[gi]),
      .mult_bits (mult_q[gi][STEP-1:0]),
      .acc_out   (acc_nxt[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d[0] = PROD_W'(a_lo);
          mcand_d[1] = PROD_W'(a_lo ^ a_hi);
          mcand_d[2] = PROD_W'(a_hi);
          mult_d[0]  = b_lo;
          mult_d[1]  = b_lo ^ b_hi;
          mult_d[2]  = b_hi;
          for (int i = 0; i < 3; i++) acc_d[i] = '0;
          cnt_d      = N_BEATS;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < 3; i++) begin
          acc_d[i]   = acc_nxt[i];
          mcand_d[i] = mcand_q[i] << STEP;
          mult_d[i]  = mult_q[i] >> STEP;
        end
        cnt_d = cnt_q - 1'b1;
        // Terminal count: this beat finishes the product, publish it directly
        // from the slice outputs.
        if (cnt_q == CNT_W'(1)) begin
          z_d     = acc_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        mcand_q[i] <= '0;
        mult_q[i]  <= '0;
        acc_q[i]   <= '0;
        z_q[i]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z0        = z_q[0];
  assign z1        = z_q[1];
  assign z2        = z_q[2];

endmodule

// File: tb/tb_kara_pp_seq.sv
// Bench for kara_pp_seq: five instances (STEP 4, 1, 2, 8, 16) on a shared
// clock and reset; fixed vectors, backpressure and reset-abort sequences,
// then random operands against a bit-pair polynomial product model.
module tb_kara_pp_seq;

  localparam int NI = 5;

  function automatic int step_of(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s  [NI];
  logic        in_ready_s  [NI];
  logic        out_valid_s [NI];
  logic        out_ready_s [NI];
  logic [31:0] a_s         [NI];
  logic [31:0] b_s         [NI];
  logic [30:0] z0_s        [NI];
  logic [30:0] z1_s        [NI];
  logic [30:0] z2_s        [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    kara_pp_seq #(
      .STEP (step_of(gi))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_s[gi]),
      .in_ready  (in_ready_s[gi]),
      .a         (a_s[gi]),
      .b         (b_s[gi]),
      .out_valid (out_valid_s[gi]),
      .out_ready (out_ready_s[gi]),
      .z0        (z0_s[gi]),
      .z1        (z1_s[gi]),
      .z2        (z2_s[gi])
    );
  end

  // Model: bit k of x*y over GF(2) is the parity of x[i]&y[j] over i+j == k.
  function automatic logic [30:0] ref_clmul(input logic [15:0] x, input logic [15:0] y);
    logic [30:0] r;
    r = '0;
    for (int k = 0; k <= 30; k++) begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (k - i >= 0 && k - i < 16) p = p ^ (x[i] & y[k-i]);
      end
      r[k] = p;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic start_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                           output bit ok);
    int g;
    g = 0;
    while (!in_ready_s[idx] && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
    ok = in_ready_s[idx];
    if (!ok) return;
    a_s[idx]        = a;
    b_s[idx]        = b;
    in_valid_s[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[idx] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; scrambles a/b meanwhile.
  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!out_valid_s[idx] && lat < 40) begin
      a_s[idx] = $urandom;
      b_s[idx] = $urandom;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input int idx, input string tag,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [30:0] e0, input logic [30:0] e1,
                               input logic [30:0] e2);
    bit ok;
    int lat;
    start_txn(idx, a, b, ok);
    if (!ok) begin
      fail_now({tag, "_accept"});
      return;
    end
    wait_done(idx, lat);
    check({tag, "_latency"}, lat, 16 / step_of(idx));
    check({tag, "_z0"}, {1'b0, z0_s[idx]}, {1'b0, e0});
    check({tag, "_z1"}, {1'b0, z1_s[idx]}, {1'b0, e1});
    check({tag, "_z2"}, {1'b0, z2_s[idx]}, {1'b0, e2});
    out_ready_s[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[idx] = 1'b0;
    check({tag, "_ovalid_drop"}, {31'b0, out_valid_s[idx]}, 32'd0);
    check({tag, "_iready_rise"}, {31'b0, in_ready_s[idx]}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [30:0] z0;
    logic [30:0] z1;
    logic [30:0] z2;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int ov_seen;

    vecs[0] = '{32'h0001_0003, 32'h0001_0005, 31'h0000000F, 31'h00000008, 31'h00000001};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 31'h55555555, 31'h00000000, 31'h55555555};
    vecs[2] = '{32'h8000_0000, 32'h8000_8000, 31'h00000000, 31'h00000000, 31'h40000000};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 31'h00000000, 31'h00000000, 31'h00000000};
    vecs[4] = '{32'h0000_0001, 32'h0000_8000, 31'h00008000, 31'h00008000, 31'h00000000};
    vecs[5] = '{32'h0002_0000, 32'h0003_0000, 31'h00000000, 31'h00000006, 31'h00000006};

    for (int i = 0; i < NI; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      a_s[i]         = '0;
      b_s[i]         = '0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready_s[0]}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid_s[0]}, 32'd0);
    check("rst_z0", {1'b0, z0_s[0]}, 32'd0);
    check("rst_z2", {1'b0, z2_s[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_in_ready_before_edge", {31'b0, in_ready_s[0]}, 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_after_edge", {31'b0, in_ready_s[0]}, 32'd1);

    // Fixed vectors on every STEP.
    for (int s = 0; s < NI; s++) begin
      for (int v = 0; v < 6; v++) begin
        run_and_check(s, $sformatf("vec%0d_step%0d", v, step_of(s)),
                      vecs[v].a, vecs[v].b, vecs[v].z0, vecs[v].z1, vecs[v].z2);
      end
    end

    // Backpressure: hold out_ready low 10 cycles while poking in_valid.
    start_txn(0, 32'h0001_0003, 32'h0001_0005, ok);
    if (!ok) fail_now("bp_accept");
    wait_done(0, lat);
    check("bp_latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      a_s[0]        = $urandom;
      b_s[0]        = $urandom;
      in_valid_s[0] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_hold_ovalid_c%0d", c), {31'b0, out_valid_s[0]}, 32'd1);
      check($sformatf("bp_hold_iready_c%0d", c), {31'b0, in_ready_s[0]}, 32'd0);
      check($sformatf("bp_hold_z0_c%0d", c), {1'b0, z0_s[0]}, 32'h0000000F);
      check($sformatf("bp_hold_z1_c%0d", c), {1'b0, z1_s[0]}, 32'h00000008);
      check($sformatf("bp_hold_z2_c%0d", c), {1'b0, z2_s[0]}, 32'h00000001);
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_consume_ovalid", {31'b0, out_valid_s[0]}, 32'd0);
    check("bp_consume_iready", {31'b0, in_ready_s[0]}, 32'd1);
    ov_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid_s[0]) ov_seen++;
    end
    out_ready_s[0] = 1'b0;
    check("bp_single_consume", ov_seen, 0);
    check("bp_z0_held_after_done", {1'b0, z0_s[0]}, 32'h0000000F);

    // Reset during the second BUSY cycle.
    start_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    if (!ok) fail_now("abort_accept");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ovalid", {31'b0, out_valid_s[0]}, 32'd0);
    check("abort_iready", {31'b0, in_ready_s[0]}, 32'd0);
    check("abort_z0", {1'b0, z0_s[0]}, 32'd0);
    check("abort_z1", {1'b0, z1_s[0]}, 32'd0);
    check("abort_z2", {1'b0, z2_s[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_rel_iready_low", {31'b0, in_ready_s[0]}, 32'd0);
    @(posedge clk); #1;
    check("abort_rel_iready_high", {31'b0, in_ready_s[0]}, 32'd1);
    ov_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid_s[0]) ov_seen++;
    end
    check("abort_no_result", ov_seen, 0);
    run_and_check(0, "post_abort", 32'h0001_0003, 32'h0001_0005,
                  31'h0000000F, 31'h00000008, 31'h00000001);

    // Random operands on every STEP against the model.
    for (int s = 0; s < NI; s++) begin
      int n;
      n = (s == 0) ? 200 : 1000;
      for (int t = 0; t < n; t++) begin
        logic [31:0] ra, rb;
        logic [15:0] al, ah, bl, bh;
        ra = $urandom;
        rb = $urandom;
        if (t % 16 == 0) ra[15:0] = 16'hFFFF;
        if (t % 16 == 1) rb[31:16] = 16'h0000;
        al = ra[15:0]; ah = ra[31:16];
        bl = rb[15:0]; bh = rb[31:16];
        run_and_check(s, $sformatf("rnd_step%0d_t%0d", step_of(s), t), ra, rb,
                      ref_clmul(al, bl), ref_clmul(al ^ ah, bl ^ bh), ref_clmul(ah, bh));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kara_pp_seq.md
# kara_pp_seq

Sequential producer of the three Karatsuba partial products for a 32x32 carry-less (GF(2)) multiply. It accepts operands a and b and splits each into 16-bit halves. It then computes z0 = a_lo·b_lo, z2 = a_hi·b_hi and z1 = (a_lo⊕a_hi)·(b_lo⊕b_hi) as 31-bit carry-less products, iterating STEP multiplier bits per cycle. It sits directly upstream of the 31-bit partial-product fold/XOR stage, whose z0/z1/z2 inputs it drives.

## Interface
- STEP, default 4, multiplier bits processed per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  sole clock; all flops rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  32  operand A; [15:0] = a_lo, [31:16] = a_hi.
- b  in  32  operand B; same split.
- out_valid  out  1  z0/z1/z2 valid.
- out_ready  in  1  consumer accepts results.
- z0  out  31  a_lo·b_lo, carry-less.
- z1  out  31  (a_lo⊕a_hi)·(b_lo⊕b_hi), carry-less.
- z2  out  31  a_hi·b_hi, carry-less.

## Operation
- Carry-less product: partial-product rows are XORed, never added. Bit k of a 16x16 product covers k = 0..30. No bit 31 exists.
- States:
  - IDLE: in_ready = 1. When in_valid = 1, the operands are accepted.
    - Latch three multiplicand registers: a_lo, a_hi, a_lo⊕a_hi, zero-extended to 31 bits.
    - Latch three multiplier registers: b_lo, b_hi, b_lo⊕b_hi, 16 bits each.
    - Clear the three accumulators and load the count with N = 16/STEP.
    - Go to BUSY.
  - BUSY: each cycle, for j = 0..STEP-1, acc ^= (mcand << j) when mult[j] = 1.
    - Then mcand <<= STEP (bits shifted past bit 30 are dropped) and mult >>= STEP. The count is decremented.
    - On the cycle the count reaches 0, copy the accumulators to z0/z1/z2 and go to DONE.
  - DONE: out_valid = 1 and z0/z1/z2 are held stable. When out_ready = 1, go to IDLE.
- in_ready and out_valid are registered state decodes. No combinational path exists from in_valid or out_ready to any output.
- Inputs a/b are sampled only on the accept edge. Changes to a/b at other times have no effect.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored, and nothing is queued.
- z0/z1/z2 keep their last values after the DONE→IDLE transition until the next DONE load.

## Timing
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, in_ready = 0, out_valid = 0.
  - z0 = z1 = z2 = 0; accumulators, count and operand registers all 0.
- Reset release: in_ready rises at the first clk edge with rst_n = 1.
- Reset mid-BUSY or mid-DONE: the operation is abandoned immediately and the outputs take their reset values. No result is ever emitted for that transaction.
- Latency: operands are accepted at edge T. out_valid = 1 after edge T+N, i.e. N BUSY cycles; N = 4 at the default STEP.
- Result handshake: completes at the first edge with out_valid & out_ready. out_valid falls and in_ready rises at that same edge.
- The next accept is possible one edge later. Minimum initiation interval is N+2 cycles with out_ready held high.
- STEP = 16 gives a single BUSY cycle and latency 1.

## Structure
- Package kara_pkg:
  - HALF_W = 16 and PROD_W = 31.
  - The state enum (IDLE, BUSY, DONE).
  - Function clmul16(a, b), a reference carry-less product for the bench and assertions.
- Sub-module clmul_step:
  - One STEP-bit slice: given acc, mcand and the low STEP bits of mult, returns the next acc. Purely combinational, parameterised by STEP.
  - Instantiated three times, once per partial product.
- The top level holds the FSM, count and registers.

## Test plan
- a = 0x0001_0003, b = 0x0001_0005, STEP = 4 -> after 4 BUSY cycles out_valid = 1 with z0 = 0x0000000F, z1 = 0x00000008, z2 = 0x00000001.
- a = b = 0xFFFF_FFFF -> z0 = z2 = 0x55555555 (bit 30 highest set bit), z1 = 0.
- a = 0x8000_0000, b = 0x8000_8000 -> z0 = 0, z1 = 0, z2 = 0x40000000.
- Backpressure: out_ready = 0 for 10 cycles after out_valid rises:
  - Outputs stay stable and in_ready stays 0.
  - in_valid pulses with new operands are ignored.
  - After out_ready = 1, the original result is consumed exactly once.
- Reset: assert rst_n = 0 for 1 cycle during the 2nd BUSY cycle -> all outputs 0 immediately. in_ready = 1 one edge after release, and no out_valid appears for the aborted operands.
- Sweep STEP ∈ {1, 2, 8, 16} with 1000 random operand pairs against clmul16 -> all match, and latency = 16/STEP every time.
